// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_arbiter
//  Purpose  : Shares one physical-memory line port between the I-cache
//             (read-only) and the D-cache (read / write-back). One line
//             transaction is granted at a time; the command is latched and
//             the response is steered only to the granted cache. Round-robin
//             on contention, plus a sticky watchdog on pmem latency.
//  Revision : 1.0  initial release
// ============================================================================
module pmem_arbiter #(
   parameter int LINE_WIDTH  = 128,
   parameter int ADDR_WIDTH  = 16,
   parameter int OFFSET_BITS = 4,
   parameter int TIMEOUT     = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  icache_read,
   input  logic [ADDR_WIDTH-1:0] icache_address,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,

   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [ADDR_WIDTH-1:0] dcache_address,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp,
   output logic                  pmem_error
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   // Clears the byte-offset bits so pmem always sees a line-aligned address.
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
   localparam logic [7:0]            TIMEOUT_VAL = 8'(TIMEOUT);
   localparam logic [7:0]            TIMER_MAX   = 8'hFF;

   state_t                  state_q,      state_d;
   logic                    last_d_q,     last_d_d;     // 1: D-cache held the last grant
   logic                    read_q,       read_d;
   logic                    write_q,      write_d;
   logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q,      wdata_d;
   logic [7:0]              timer_q,      timer_d;
   logic                    error_q,      error_d;

   logic                    d_req;
   logic                    grant_d;

   assign d_req = dcache_read | dcache_write;

   // Next-state logic: arbitration, command latching, and latency watchdog.
   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      read_d   = read_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      timer_d  = timer_q;
      error_d  = error_q;
      grant_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (icache_read || d_req) begin
               // On contention the cache that did not win last time goes first.
               grant_d = d_req && (!icache_read || !last_d_q);
               timer_d = 8'd0;
               if (grant_d) begin
                  state_d  = ST_SERVE_D;
                  last_d_d = 1'b1;
                  addr_d   = dcache_address & ADDR_MASK;
                  wdata_d  = dcache_wdata;
                  // A simultaneous read+write from the D-cache resolves to write.
                  write_d  = dcache_write;
                  read_d   = ~dcache_write;
               end else begin
                  state_d  = ST_SERVE_I;
                  last_d_d = 1'b0;
                  addr_d   = icache_address & ADDR_MASK;
                  read_d   = 1'b1;
                  write_d  = 1'b0;
               end
            end
         end

         ST_SERVE_I, ST_SERVE_D: begin
            if (pmem_resp) begin
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = ST_RECOVER;
            end else begin
               if (timer_q != TIMER_MAX) begin
                  timer_d = timer_q + 8'd1;
               end
               // Keep waiting after a timeout; the flag only reports it.
               if (timer_d >= TIMEOUT_VAL) begin
                  error_d = 1'b1;
               end
            end
         end

         ST_RECOVER: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered pmem command; async reset aborts any transaction at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         last_d_q <= 1'b0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         timer_q  <= 8'd0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         read_q   <= read_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         timer_q  <= timer_d;
         error_q  <= error_d;
      end
   end

   assign pmem_read    = read_q;
   assign pmem_write   = write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign pmem_error   = error_q;

   // Responses go only to the granted cache, and only if it is still asking.
   assign icache_resp  = (state_q == ST_SERVE_I) && pmem_resp && icache_read;
   assign dcache_resp  = (state_q == ST_SERVE_D) && pmem_resp && d_req;
   assign icache_rdata = (state_q == ST_SERVE_I) ? pmem_rdata : '0;
   assign dcache_rdata = (state_q == ST_SERVE_D) ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_arbiter
//  Purpose  : Directed self-checking bench for pmem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmem_arbiter;

   localparam int LW = 128;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          icache_read = 1'b0;
   logic [AW-1:0] icache_address = '0;
   logic [LW-1:0] icache_rdata;
   logic          icache_resp;
   logic          dcache_read = 1'b0;
   logic          dcache_write = 1'b0;
   logic [AW-1:0] dcache_address = '0;
   logic [LW-1:0] dcache_wdata = '0;
   logic [LW-1:0] dcache_rdata;
   logic          dcache_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;
   logic          pmem_error;

   int n_total = 0;
   int n_pass  = 0;

   pmem_arbiter #(
      .LINE_WIDTH  (LW),
      .ADDR_WIDTH  (AW),
      .OFFSET_BITS (4),
      .TIMEOUT     (255)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .icache_read    (icache_read),
      .icache_address (icache_address),
      .icache_rdata   (icache_rdata),
      .icache_resp    (icache_resp),
      .dcache_read    (dcache_read),
      .dcache_write   (dcache_write),
      .dcache_address (dcache_address),
      .dcache_wdata   (dcache_wdata),
      .dcache_rdata   (dcache_rdata),
      .dcache_resp    (dcache_resp),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_address   (pmem_address),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp),
      .pmem_error     (pmem_error)
   );

   always #5 clk = ~clk;

   // The D-cache must never ask for read and write together; pmem commands are exclusive.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(dcache_read && dcache_write))
            else $error("FAIL d_rw_exclusive: dcache_read and dcache_write both 1");
         assert (!(pmem_read && pmem_write))
            else $error("FAIL pmem_rw_exclusive: pmem_read and pmem_write both 1");
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of test, want finish");
      $fatal(1, "bench timeout");
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      #1;
      n_total++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read: got %0b want 0", pmem_read); else n_pass++;
      n_total++; if (pmem_write !== 1'b0) $display("FAIL reset_pmem_write: got %0b want 0", pmem_write); else n_pass++;
      n_total++; if (pmem_address !== 16'h0000) $display("FAIL reset_pmem_address: got %h want 0000", pmem_address); else n_pass++;
      n_total++; if (pmem_wdata !== '0) $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); else n_pass++;
      n_total++; if (pmem_error !== 1'b0) $display("FAIL reset_pmem_error: got %0b want 0", pmem_error); else n_pass++;
      n_total++; if (icache_resp !== 1'b0) $display("FAIL reset_icache_resp: got %0b want 0", icache_resp); else n_pass++;
      n_total++; if (dcache_resp !== 1'b0) $display("FAIL reset_dcache_resp: got %0b want 0", dcache_resp); else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   // Both caches request continuously from reset: expect D, I, D, I.
   task automatic test_contention();
      logic [LW-1:0] line;
      logic          exp_d;
      logic [AW-1:0] exp_addr;
      icache_read    = 1'b1;
      icache_address = 16'h1105;
      dcache_read    = 1'b1;
      dcache_address = 16'h22FA;
      for (int k = 0; k < 4; k++) begin
         exp_d    = (k % 2 == 0);
         exp_addr = exp_d ? 16'h22F0 : 16'h1100;
         line     = {4{32'hC0DE_0000 + 32'(k)}};
         step(); #1;
         n_total++; if (pmem_read !== 1'b1) $display("FAIL rr_pmem_read[%0d]: got %0b want 1", k, pmem_read); else n_pass++;
         n_total++; if (pmem_address !== exp_addr) $display("FAIL rr_grant_addr[%0d]: got %h want %h", k, pmem_address, exp_addr); else n_pass++;
         step();
         pmem_resp = 1'b1; pmem_rdata = line; #1;
         n_total++; if (icache_resp !== !exp_d) $display("FAIL rr_icache_resp[%0d]: got %0b want %0b", k, icache_resp, !exp_d); else n_pass++;
         n_total++; if (dcache_resp !== exp_d) $display("FAIL rr_dcache_resp[%0d]: got %0b want %0b", k, dcache_resp, exp_d); else n_pass++;
         if (exp_d) begin
            n_total++; if (dcache_rdata !== line) $display("FAIL rr_dcache_rdata[%0d]: got %h want %h", k, dcache_rdata, line); else n_pass++;
         end else begin
            n_total++; if (icache_rdata !== line) $display("FAIL rr_icache_rdata[%0d]: got %h want %h", k, icache_rdata, line); else n_pass++;
         end
         step();
         pmem_resp = 1'b0; pmem_rdata = '0; #1;
         n_total++; if (pmem_read !== 1'b0) $display("FAIL rr_recover_read[%0d]: got %0b want 0", k, pmem_read); else n_pass++;
         step(); #1;
         n_total++; if (pmem_read !== 1'b0) $display("FAIL rr_idle_read[%0d]: got %0b want 0", k, pmem_read); else n_pass++;
      end
      icache_read = 1'b0;
      dcache_read = 1'b0;
   endtask

   // Lone I read of an unaligned address, pmem answers in the third cycle.
   task automatic test_i_read();
      logic [LW-1:0] line;
      line           = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      icache_read    = 1'b1;
      icache_address = 16'h1234;
      step(); #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL iread_c1_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (pmem_write !== 1'b0) $display("FAIL iread_c1_write: got %0b want 0", pmem_write); else n_pass++;
      n_total++; if (pmem_address !== 16'h1230) $display("FAIL iread_addr: got %h want 1230", pmem_address); else n_pass++;
      step(); #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL iread_c2_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (icache_resp !== 1'b0) $display("FAIL iread_c2_resp: got %0b want 0", icache_resp); else n_pass++;
      step();
      pmem_resp = 1'b1; pmem_rdata = line; #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL iread_c3_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (icache_resp !== 1'b1) $display("FAIL iread_c3_resp: got %0b want 1", icache_resp); else n_pass++;
      n_total++; if (icache_rdata !== line) $display("FAIL iread_rdata: got %h want %h", icache_rdata, line); else n_pass++;
      n_total++; if (dcache_resp !== 1'b0) $display("FAIL iread_dcache_resp: got %0b want 0", dcache_resp); else n_pass++;
      n_total++; if (dcache_rdata !== '0) $display("FAIL iread_dcache_rdata: got %h want 0", dcache_rdata); else n_pass++;
      step();
      pmem_resp = 1'b0; pmem_rdata = '0; icache_read = 1'b0; #1;
      n_total++; if (pmem_read !== 1'b0) $display("FAIL iread_c4_read: got %0b want 0", pmem_read); else n_pass++;
      n_total++; if (icache_resp !== 1'b0) $display("FAIL iread_c4_resp: got %0b want 0", icache_resp); else n_pass++;
      step();
   endtask

   // D write-back; requester scrambles its inputs right after the grant edge.
   task automatic test_d_write();
      logic [LW-1:0] a5;
      a5             = {16{8'hA5}};
      dcache_write   = 1'b1;
      dcache_address = 16'h8000;
      dcache_wdata   = a5;
      step();
      dcache_address = 16'h7FFF;
      dcache_wdata   = '0;
      #1;
      n_total++; if (pmem_write !== 1'b1) $display("FAIL dwr_c1_write: got %0b want 1", pmem_write); else n_pass++;
      n_total++; if (pmem_read !== 1'b0) $display("FAIL dwr_c1_read: got %0b want 0", pmem_read); else n_pass++;
      n_total++; if (pmem_address !== 16'h8000) $display("FAIL dwr_c1_addr: got %h want 8000", pmem_address); else n_pass++;
      n_total++; if (pmem_wdata !== a5) $display("FAIL dwr_c1_wdata: got %h want %h", pmem_wdata, a5); else n_pass++;
      step(); #1;
      n_total++; if (pmem_address !== 16'h8000) $display("FAIL dwr_c2_addr: got %h want 8000", pmem_address); else n_pass++;
      n_total++; if (pmem_wdata !== a5) $display("FAIL dwr_c2_wdata: got %h want %h", pmem_wdata, a5); else n_pass++;
      step();
      pmem_resp = 1'b1; #1;
      n_total++; if (pmem_write !== 1'b1) $display("FAIL dwr_c3_write: got %0b want 1", pmem_write); else n_pass++;
      n_total++; if (dcache_resp !== 1'b1) $display("FAIL dwr_dcache_resp: got %0b want 1", dcache_resp); else n_pass++;
      n_total++; if (icache_resp !== 1'b0) $display("FAIL dwr_icache_resp: got %0b want 0", icache_resp); else n_pass++;
      step();
      pmem_resp = 1'b0; dcache_write = 1'b0; #1;
      n_total++; if (pmem_write !== 1'b0) $display("FAIL dwr_c4_write: got %0b want 0", pmem_write); else n_pass++;
      step();
   endtask

   // I drops its request mid-service; then a D request raised in RECOVER waits for IDLE.
   task automatic test_drop();
      icache_read    = 1'b1;
      icache_address = 16'h4321;
      step();
      icache_read = 1'b0;
      #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL drop_c1_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (pmem_address !== 16'h4320) $display("FAIL drop_addr: got %h want 4320", pmem_address); else n_pass++;
      step(); #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL drop_c2_read: got %0b want 1", pmem_read); else n_pass++;
      step();
      pmem_resp = 1'b1; #1;
      n_total++; if (icache_resp !== 1'b0) $display("FAIL drop_icache_resp: got %0b want 0", icache_resp); else n_pass++;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL drop_c3_read: got %0b want 1", pmem_read); else n_pass++;
      step();
      pmem_resp = 1'b0; dcache_read = 1'b1; dcache_address = 16'h0050; #1;
      n_total++; if (pmem_read !== 1'b0) $display("FAIL drop_recover_read: got %0b want 0", pmem_read); else n_pass++;
      step(); #1;
      n_total++; if (pmem_read !== 1'b0) $display("FAIL drop_idle_read: got %0b want 0", pmem_read); else n_pass++;
      step(); #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL drop_next_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (pmem_address !== 16'h0050) $display("FAIL drop_next_addr: got %h want 0050", pmem_address); else n_pass++;
      step();
      pmem_resp = 1'b1; #1;
      n_total++; if (dcache_resp !== 1'b1) $display("FAIL drop_next_resp: got %0b want 1", dcache_resp); else n_pass++;
      step();
      pmem_resp = 1'b0; dcache_read = 1'b0;
      step();
   endtask

   // pmem withholds its response for 300 cycles; the flag sets and sticks.
   task automatic test_watchdog();
      icache_read    = 1'b1;
      icache_address = 16'h0A00;
      step();
      for (int cyc = 1; cyc < 300; cyc++) begin
         #1;
         if (cyc == 250) begin
            n_total++; if (pmem_error !== 1'b0) $display("FAIL wd_early_error: got %0b want 0", pmem_error); else n_pass++;
         end
         if (cyc == 260) begin
            n_total++; if (pmem_error !== 1'b1) $display("FAIL wd_late_error: got %0b want 1", pmem_error); else n_pass++;
            n_total++; if (pmem_read !== 1'b1) $display("FAIL wd_still_read: got %0b want 1", pmem_read); else n_pass++;
         end
         step();
      end
      pmem_resp = 1'b1; #1;
      n_total++; if (icache_resp !== 1'b1) $display("FAIL wd_late_resp: got %0b want 1", icache_resp); else n_pass++;
      step();
      pmem_resp = 1'b0; icache_read = 1'b0; #1;
      n_total++; if (pmem_error !== 1'b1) $display("FAIL wd_sticky_error: got %0b want 1", pmem_error); else n_pass++;
      step();
      icache_read    = 1'b1;
      icache_address = 16'h0B00;
      step(); #1;
      n_total++; if (pmem_address !== 16'h0B00) $display("FAIL wd_resume_addr: got %h want 0B00", pmem_address); else n_pass++;
      step();
      pmem_resp = 1'b1; #1;
      n_total++; if (icache_resp !== 1'b1) $display("FAIL wd_resume_resp: got %0b want 1", icache_resp); else n_pass++;
      step();
      pmem_resp = 1'b0; icache_read = 1'b0;
      step();
   endtask

   // Reset asserted during a D write; a pending I read is served after release.
   task automatic test_reset_mid();
      dcache_write   = 1'b1;
      dcache_address = 16'h3000;
      dcache_wdata   = {16{8'h5A}};
      step(); #1;
      n_total++; if (pmem_write !== 1'b1) $display("FAIL rmid_pre_write: got %0b want 1", pmem_write); else n_pass++;
      icache_read    = 1'b1;
      icache_address = 16'h6010;
      #2;
      rst_n     = 1'b0;
      pmem_resp = 1'b1;
      #1;
      n_total++; if (pmem_write !== 1'b0) $display("FAIL rmid_write_drop: got %0b want 0", pmem_write); else n_pass++;
      n_total++; if (dcache_resp !== 1'b0) $display("FAIL rmid_no_resp: got %0b want 0", dcache_resp); else n_pass++;
      n_total++; if (pmem_error !== 1'b0) $display("FAIL rmid_error_clear: got %0b want 0", pmem_error); else n_pass++;
      step();
      pmem_resp    = 1'b0;
      dcache_write = 1'b0;
      rst_n        = 1'b1;
      step(); #1;
      n_total++; if (pmem_read !== 1'b1) $display("FAIL rmid_i_read: got %0b want 1", pmem_read); else n_pass++;
      n_total++; if (pmem_write !== 1'b0) $display("FAIL rmid_i_write: got %0b want 0", pmem_write); else n_pass++;
      n_total++; if (pmem_address !== 16'h6010) $display("FAIL rmid_i_addr: got %h want 6010", pmem_address); else n_pass++;
      step();
      pmem_resp = 1'b1; #1;
      n_total++; if (icache_resp !== 1'b1) $display("FAIL rmid_i_resp: got %0b want 1", icache_resp); else n_pass++;
      n_total++; if (dcache_resp !== 1'b0) $display("FAIL rmid_d_resp: got %0b want 0", dcache_resp); else n_pass++;
      step();
      pmem_resp = 1'b0; icache_read = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_i_read();
      test_d_write();
      test_drop();
      test_watchdog();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
